sum_latch_uart_core: RTL and testbench
======================================

Name: sum_latch_uart_core

Overview:
Parametrised successor to the fixed 4-bit sum-latch UART datapath. It latches two DATA_W-bit operands from a shared input bus on separate active-low save strobes, and computes their sum or difference at DATA_W+1 bits. After every save event it transmits the result as one or more 8N1 UART bytes, LSB byte first, with a single-depth pending request so saves made during a transmission are never lost. It sits directly under the Tiny Tapeout top wrapper and drives the UART pin and the busy flag.

Parameters:
- DATA_W, 4, operand width; legal range 2..16.
- CLKS_PER_BIT, 434, clk cycles per UART bit; minimum 2.
- SYNC_STAGES, 2, synchroniser depth for save_a_n, save_b_n and op_sub; minimum 2.
- Derived, not overridable: RES_W = DATA_W+1; NBYTES = ceil(RES_W/8).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- save_a_n  input  1  async active-low strobe; a falling edge latches operand A
- save_b_n  input  1  async active-low strobe; a falling edge latches operand B
- op_sub  input  1  async level; 0 = A+B, 1 = A-B
- data_input  input  DATA_W  operand bus; sampled at the save strobe
- result  output  RES_W  registered arithmetic result
- uart_txd  output  1  UART serial output; idles at 1
- uart_tx_busy  output  1  high while a frame sequence is in progress

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset state: op_a=0, op_b=0, result=0, uart_txd=1, uart_tx_busy=0, request=0, FSM=IDLE, all bit and byte counters 0.
- Synchronisers reset to the inactive value: 1 for the save inputs, 0 for op_sub.
- Save event: a 1->0 transition on the synchronised save signal produces a one-cycle strobe. The strobe fires SYNC_STAGES+1 cycles after the pin falls.
- On the strobe cycle, data_input is written directly into op_a or op_b. The driver must hold data_input stable from the pin edge until the strobe.
- Simultaneous save_a and save_b strobes: both operands load the same data, and only one request is raised.
- Arithmetic: result is registered one cycle after any operand or op_sub change.
  - Add: result = zero-extended op_a + op_b. It never overflows RES_W.
  - Subtract: result = (op_a - op_b) mod 2^RES_W, i.e. a two's-complement RES_W value.
- Request flag: set by any save strobe, cleared when the FSM enters LOAD. Multiple strobes before LOAD coalesce into one request.
- FSM states: IDLE, LOAD, START, DATA, STOP.
- IDLE: uart_txd=1, busy=0. If request=1, go to LOAD on the next cycle.
- LOAD, 1 cycle:
  - Snapshot result into an NBYTES*8 shift buffer, zero-padding the bits above RES_W.
  - Set byte_idx=0 and busy=1.
  - Go to START. The snapshot is taken at least one cycle after the operand update, so the frame carries the new result.
- START: uart_txd=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: send 8 bits LSB first, each held for CLKS_PER_BIT cycles, then go to STOP.
- STOP: uart_txd=1 for CLKS_PER_BIT cycles.
  - If byte_idx < NBYTES-1: increment byte_idx, shift the buffer by 8, go to START.
  - Otherwise go to IDLE.
- Busy and frame length:
  - uart_tx_busy is high from LOAD through the last stop-bit cycle.
  - One sequence is exactly 1 + NBYTES*10*CLKS_PER_BIT cycles of busy.
  - After every sequence there is at least one IDLE cycle with busy=0.
- Save during transmission: the operand updates immediately and result follows. The in-flight frame is unaffected because it uses the snapshot. The request stays pending, and the next sequence starts right after the mandatory IDLE cycle, carrying the latest result.
- Save during the LOAD cycle: the request is set again and is serviced as a new sequence.
- Reset mid-operation: uart_txd goes to 1 and busy goes to 0 asynchronously. The partial frame is abandoned and no pending frame is sent.
- Glitch tolerance: a pin low for less than one clk cycle may be missed; no other filtering.

Test Plan:
1. DATA_W=4, CLKS_PER_BIT=4, op_sub=0. data=5 then save_a; later data=9 then save_b -> two sequences, bytes 0x05 then 0x0E. result=14. Each sequence has 41 busy cycles.
2. DATA_W=4, op_sub=1. A=3, B=5 -> result=5'h1E, UART byte 0x1E.
3. DATA_W=12. A=0xFFF, B=0x001, add -> result=13'h1000, bytes 0x00 then 0x10, busy for 81 cycles at CLKS_PER_BIT=4.
4. Three save_b strobes with data 1, 2, 3 during the DATA phase of a frame -> exactly one extra sequence, carrying A+3. The in-flight byte is unchanged.
5. save_a_n and save_b_n fall on the same clk with data=7 -> op_a=op_b=7, result=14, exactly one sequence.
6. Assert reset during the 4th data bit -> uart_txd=1 and busy=0 before the next clk edge. result=0. No further frames after release even though a save was pending.

Source files
------------

// File: rtl/sum_latch_uart_if.sv
// sum_latch_uart_if: operand strobes, operand bus, result and UART pins of the sum-latch core
interface sum_latch_uart_if #(parameter int DATA_W = 4);
    logic              save_a_n;
    logic              save_b_n;
    logic              op_sub;
    logic [DATA_W-1:0] data_input;
    logic [DATA_W:0]   result;
    logic              uart_txd;
    logic              uart_tx_busy;
    modport master (
        output save_a_n, save_b_n, op_sub, data_input,
        input  result, uart_txd, uart_tx_busy
    );
    modport slave (
        input  save_a_n, save_b_n, op_sub, data_input,
        output result, uart_txd, uart_tx_busy
    );
endinterface

// File: rtl/sum_latch_uart_core.sv
// sum_latch_uart_core: latches two operands on save strobes, adds/subtracts them and sends the result over 8N1 UART
module sum_latch_uart_core #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input logic clk,
    input logic reset,
    sum_latch_uart_if.slave bus
);
    localparam int RES_W  = DATA_W + 1;
    localparam int NBYTES = (RES_W + 7) / 8;
    localparam int BUF_W  = NBYTES * 8;
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int BW     = NBYTES > 1 ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t             state, state_next;
    logic [SYNC_STAGES-1:0] sync_a, sync_b, sync_s;
    logic               prev_a, prev_b;
    logic               stb_a, stb_b, request;
    logic [DATA_W-1:0]  op_a, op_b;
    logic [RES_W-1:0]   result;
    logic [BUF_W-1:0]   shift_buf;
    logic [CW-1:0]      clk_cnt;
    logic [2:0]         bit_idx;
    logic [BW-1:0]      byte_idx;
    logic               tick, last_byte;

    assign stb_a     = prev_a & ~sync_a[SYNC_STAGES-1];
    assign stb_b     = prev_b & ~sync_b[SYNC_STAGES-1];
    assign tick      = clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign last_byte = byte_idx == BW'(NBYTES - 1);

    assign bus.result       = result;
    assign bus.uart_tx_busy = state != IDLE;
    assign bus.uart_txd     = state == START ? 1'b0 : state == DATA ? shift_buf[bit_idx] : 1'b1;

    // synchronise the asynchronous pins and keep the previous save level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '1;
            sync_b <= '1;
            sync_s <= '0;
            prev_a <= 1'b1;
            prev_b <= 1'b1;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], bus.save_a_n};
            sync_b <= {sync_b[SYNC_STAGES-2:0], bus.save_b_n};
            sync_s <= {sync_s[SYNC_STAGES-2:0], bus.op_sub};
            prev_a <= sync_a[SYNC_STAGES-1];
            prev_b <= sync_b[SYNC_STAGES-1];
        end
    end

    // operand latches, registered arithmetic and the coalescing transmit request (a new strobe beats the LOAD clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a    <= '0;
            op_b    <= '0;
            result  <= '0;
            request <= 1'b0;
        end else begin
            if (stb_a) op_a <= bus.data_input;
            if (stb_b) op_b <= bus.data_input;
            result  <= sync_s[SYNC_STAGES-1] ? RES_W'(op_a) - RES_W'(op_b) : RES_W'(op_a) + RES_W'(op_b);
            request <= stb_a | stb_b | (request & (state_next != LOAD));
        end
    end

    // transmitter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // transmitter next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = LOAD;
            LOAD:    state_next = START;
            START:   if (tick) state_next = DATA;
            DATA:    if (tick && bit_idx == 3'd7) state_next = STOP;
            STOP:    if (tick) state_next = last_byte ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // bit timer, bit/byte counters and the result snapshot shifted out one byte per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_buf <= '0;
        end else begin
            clk_cnt <= (state == IDLE || state == LOAD || tick) ? '0 : clk_cnt + 1'b1;
            if (state == LOAD) begin
                bit_idx   <= '0;
                byte_idx  <= '0;
                shift_buf <= BUF_W'(result);
            end else begin
                if (state == DATA && tick) bit_idx <= bit_idx + 1'b1;
                if (state == STOP && tick && !last_byte) begin
                    byte_idx  <= byte_idx + 1'b1;
                    shift_buf <= shift_buf >> 8;
                end
            end
        end
    end
endmodule

// File: tb/tb_sum_latch_uart_core.sv
// tb_sum_latch_uart_core: directed and random saves checked against an arithmetic/byte-queue reference model
module tb_sum_latch_uart_core;
    localparam int DW  = 12;
    localparam int CPB = 4;
    localparam int SEQ_LEN = 1 + 2 * 10 * CPB;

    logic clk = 0;
    logic reset = 1;
    int checks = 0;
    int errors = 0;
    int ma = 0, mb = 0, msub = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int len_q[$];
    int run = 0, cnt = 0;
    bit active = 0;
    logic [7:0] sh = 0;

    sum_latch_uart_if #(.DATA_W(DW)) ifc();
    sum_latch_uart_core #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    // UART receiver and busy-length monitor sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
            active = 0;
            cnt = 0;
        end else begin
            if (ifc.uart_tx_busy) run++;
            else if (run != 0) begin
                len_q.push_back(run);
                run = 0;
            end
            if (!active) begin
                if (ifc.uart_txd === 1'b0) begin
                    active = 1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == CPB * 9 + CPB / 2) begin
                    rx_q.push_back(sh);
                    active = 0;
                end else if ((cnt - CPB / 2) % CPB == 0) sh = {ifc.uart_txd, sh[7:1]};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mres();
        int r;
        r = msub != 0 ? ma - mb : ma + mb;
        return r & 'h1FFF;
    endfunction

    task automatic push_seq(input int r);
        logic [15:0] v;
        v = 16'(r);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
    endtask

    task automatic save(input bit a, input bit b, input int v);
        @(posedge clk);
        #1;
        ifc.data_input = DW'(v);
        if (a) ifc.save_a_n = 0;
        if (b) ifc.save_b_n = 0;
        repeat (3) @(posedge clk);
        #1;
        ifc.save_a_n = 1;
        ifc.save_b_n = 1;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_save(input bit a, input bit b, input int v);
        save(a, b, v);
        if (a) ma = v;
        if (b) mb = v;
        push_seq(mres());
    endtask

    task automatic set_sub(input int s);
        @(posedge clk);
        #1 ifc.op_sub = s[0];
        msub = s;
        repeat (6) @(posedge clk);
    endtask

    task automatic wait_quiet();
        int idle = 0;
        int n = 0;
        while (idle < 20 && n < 3000) begin
            @(negedge clk);
            n++;
            idle = ifc.uart_tx_busy ? 0 : idle + 1;
        end
        chk("quiet_timeout", 32'(idle >= 20), 1);
    endtask

    task automatic check_seqs(input string tag);
        chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        chk({tag, "_nseq"}, len_q.size(), exp_q.size() / 2);
        foreach (exp_q[i]) if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        foreach (len_q[i]) chk($sformatf("%s_busylen%0d", tag, i), len_q[i], SEQ_LEN);
        chk({tag, "_result"}, 32'(ifc.result), mres());
        rx_q.delete();
        exp_q.delete();
        len_q.delete();
    endtask

    initial begin
        int n;
        ifc.save_a_n = 1;
        ifc.save_b_n = 1;
        ifc.op_sub = 0;
        ifc.data_input = 0;
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(ifc.result), 0);
        chk("rst_txd", 32'(ifc.uart_txd), 1);
        chk("rst_busy", 32'(ifc.uart_tx_busy), 0);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("idle_txd", 32'(ifc.uart_txd), 1);

        do_save(1, 0, 5);
        wait_quiet();
        do_save(0, 1, 9);
        wait_quiet();
        check_seqs("add_5_9");

        set_sub(1);
        do_save(1, 0, 3);
        wait_quiet();
        do_save(0, 1, 5);
        wait_quiet();
        check_seqs("sub_3_5");

        set_sub(0);
        do_save(1, 0, 'hFFF);
        wait_quiet();
        do_save(0, 1, 1);
        wait_quiet();
        check_seqs("carry_fff_1");

        do_save(1, 0, 'h100);
        wait_quiet();
        rx_q.delete();
        exp_q.delete();
        len_q.delete();
        do_save(0, 1, 0);
        repeat (4) @(posedge clk);
        save(0, 1, 1);
        save(0, 1, 2);
        save(0, 1, 3);
        mb = 3;
        push_seq(mres());
        wait_quiet();
        check_seqs("coalesce");

        do_save(1, 1, 7);
        wait_quiet();
        check_seqs("simul_7");
        chk("simul_sum", 32'(ifc.result), 14);

        for (int i = 0; i < 6; i++) begin
            set_sub(int'($urandom_range(0, 1)));
            do_save(1, 0, int'($urandom_range(0, 4095)));
            wait_quiet();
            do_save(0, 1, int'($urandom_range(0, 4095)));
            wait_quiet();
            check_seqs($sformatf("rand%0d", i));
        end

        save(1, 0, 'h0AA);
        n = 0;
        while (!ifc.uart_tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_rise_timeout", 32'(ifc.uart_tx_busy), 1);
        save(0, 1, 'h055);
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (!active || cnt >= CPB * 4 + CPB / 2) break;
        end
        chk("mid_bit3_txd_active", 32'(active), 1);
        #1 reset = 1;
        #1;
        chk("async_rst_txd", 32'(ifc.uart_txd), 1);
        chk("async_rst_busy", 32'(ifc.uart_tx_busy), 0);
        chk("async_rst_result", 32'(ifc.result), 0);
        repeat (2) @(negedge clk);
        reset = 0;
        rx_q.delete();
        len_q.delete();
        repeat (300) @(negedge clk);
        chk("post_rst_bytes", rx_q.size(), 0);
        chk("post_rst_seqs", len_q.size(), 0);
        chk("post_rst_busy", 32'(ifc.uart_tx_busy), 0);
        chk("post_rst_result", 32'(ifc.result), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
